// File: rtl/icon_loader.sv
// Writer side of the double-buffered icon RAM: unpacks bytes of packed pixels
// into the back buffer and swaps buffers on the next vblank rise after a full icon.
module icon_loader #(
    parameter int ICON_WIDTH  = 16,
    parameter int ICON_HEIGHT = 16,
    parameter int PIX_W       = 2,
    parameter int ADDR_W      = 12,
    parameter int BUF_STRIDE  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              vblank,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_din,
    output logic              front_sel,
    output logic              busy,
    output logic              done
);

    localparam int NPIX  = ICON_WIDTH * ICON_HEIGHT;
    localparam int PPB   = 8 / PIX_W;
    localparam int IDX_W = $clog2(NPIX + 1);
    localparam int SUB_W = (PPB > 1) ? $clog2(PPB) : 1;

    localparam logic [IDX_W-1:0]  NPIX_I   = IDX_W'(NPIX);
    localparam logic [SUB_W-1:0]  LAST_SUB = SUB_W'(PPB - 1);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(BUF_STRIDE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_VB = 2'd2,
        SWAP    = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic                front_sel_reg;
    logic                vblank_q_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [7:0]          hold_reg;
    logic [SUB_W-1:0]    sub_reg;
    logic                hold_valid_reg;
    logic                ram_we_reg;
    logic [ADDR_W-1:0]   ram_addr_reg;
    logic [PIX_W-1:0]    ram_din_reg;

    logic                vb_rise;
    logic                load_done;
    logic                accept;
    logic                swap_go;
    logic [ADDR_W-1:0]   back_base;
    logic [PIX_W-1:0]    pix [PPB];

    genvar gi;
    generate
        for (gi = 0; gi < PPB; gi++) begin : g_unpack
            assign pix[gi] = hold_reg[gi*PIX_W +: PIX_W];
        end
    endgenerate

    assign vb_rise   = vblank && !vblank_q_reg;
    assign back_base = front_sel_reg ? '0 : STRIDE_A;
    // hold_valid_reg means pixels remain to be emitted; once clear, the pixel on
    // the port (if any) is the last of its byte, so the next byte can be taken.
    assign wr_ready  = (state_reg == LOAD) && !hold_valid_reg &&
                       (idx_reg < NPIX_I) && !start;
    assign accept    = wr_valid && wr_ready;
    // Final pixel is on the port this cycle.
    assign load_done = ram_we_reg && !hold_valid_reg && (idx_reg == NPIX_I);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done       = 1'b0;
        swap_go    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                if (start)          state_next = LOAD;
                else if (load_done) state_next = WAIT_VB;
            end
            WAIT_VB: begin
                if (start) begin
                    state_next = LOAD;
                end else if (vb_rise) begin
                    state_next = SWAP;
                    swap_go    = 1'b1;
                end
            end
            SWAP: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_sel_reg  <= 1'b0;
            vblank_q_reg   <= 1'b0;
            idx_reg        <= '0;
            hold_reg       <= '0;
            sub_reg        <= '0;
            hold_valid_reg <= 1'b0;
            ram_we_reg     <= 1'b0;
            ram_addr_reg   <= '0;
            ram_din_reg    <= '0;
        end else begin
            vblank_q_reg <= vblank;
            ram_we_reg   <= 1'b0;
            if (swap_go) front_sel_reg <= ~front_sel_reg;

            // A restart drops any pixels still held from the abandoned byte.
            if (start && state_reg != SWAP) begin
                idx_reg        <= '0;
                sub_reg        <= '0;
                hold_valid_reg <= 1'b0;
            end else if (state_reg == LOAD) begin
                if (accept) begin
                    hold_reg       <= wr_data;
                    ram_we_reg     <= 1'b1;
                    ram_din_reg    <= wr_data[PIX_W-1:0];
                    ram_addr_reg   <= back_base + ADDR_W'(idx_reg);
                    idx_reg        <= idx_reg + IDX_W'(1);
                    sub_reg        <= SUB_W'(1);
                    hold_valid_reg <= (PPB > 1);
                end else if (hold_valid_reg) begin
                    ram_we_reg     <= 1'b1;
                    ram_din_reg    <= pix[sub_reg];
                    ram_addr_reg   <= back_base + ADDR_W'(idx_reg);
                    idx_reg        <= idx_reg + IDX_W'(1);
                    sub_reg        <= sub_reg + SUB_W'(1);
                    hold_valid_reg <= (sub_reg != LAST_SUB);
                end
            end
        end
    end

    assign ram_we    = ram_we_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_din   = ram_din_reg;
    assign front_sel = front_sel_reg;

endmodule
